// File: rtl/reduce_channel_arbiter.sv
// reduce_channel_arbiter: round-robin share of one pipelined reduce datapath
// among NUM_REQ requesters, with tag routing of results and a drain handshake.
//
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   req_valid/data  per-requester request and operand (i at [i*WIDTH +: WIDTH])
//   req_ready       one-hot grant; transfer on valid & ready
//   dp_in_valid/data  datapath drive (same cycle as the grant)
//   dp_result       datapath output, PIPE_LATENCY cycles after sampling
//   rsp_valid/data  one-cycle response pulse to the originating requester
//   drain_req/done  quiesce request / drained indication
//   busy            any operation in flight
//   grant_count     per-requester saturating grant counters
//                   (only when REDUCE_ARB_STATS_EN is defined)
module reduce_channel_arbiter #(
  parameter int WIDTH        = 16,
  parameter int NUM_REQ      = 4,
  parameter int PIPE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     dp_in_valid,
  output logic [WIDTH-1:0]         dp_in_data,
  input  logic [WIDTH-1:0]         dp_result,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     busy
`ifdef REDUCE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_count
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
  } tag_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic          grant;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  tag_t          tags [PIPE_LATENCY];
  tag_t          last;

  // Rotating priority search starting at rr_ptr.
  // Grants are also masked while reset is asserted.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    cand  = '0;
    if (state == S_RUN && rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        cand = IW'((int'(rr_ptr) + off) % NUM_REQ);
        if (!grant && req_valid[cand]) begin
          grant = 1'b1;
          win   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    dp_in_valid = grant;
    dp_in_data  = '0;
    if (grant) begin
      req_ready  = NUM_REQ'(1) << win;
      dp_in_data = req_data[win*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      if (win == IW'(NUM_REQ-1))
        rr_ptr <= '0;
      else
        rr_ptr <= win + 1'b1;
    end
  end

  // Tag pipeline mirrors the datapath latency; no stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LATENCY; i++)
        tags[i] <= '0;
    end else begin
      tags[0] <= '{v: grant, idx: win};
      for (int i = 1; i < PIPE_LATENCY; i++)
        tags[i] <= tags[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < PIPE_LATENCY; i++)
      busy = busy | tags[i].v;
  end

  assign last = tags[PIPE_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (last.v) begin
      rsp_valid = NUM_REQ'(1) << last.idx;
      rsp_data  = dp_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:   if (drain_req) state_nxt = S_DRAIN;
      S_DRAIN: if (!busy)     state_nxt = S_DONE;
      S_DONE:  if (!drain_req) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  assign drain_done = (state == S_DONE);

`ifdef REDUCE_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt[i] <= '0;
    end else if (grant && cnt[win] != 16'hFFFF) begin
      cnt[win] <= cnt[win] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant_count[i*16 +: 16] = cnt[i];
  end
`endif

endmodule
